uart_tx_queue: RTL and testbench
================================

# uart_tx_queue

Transmit-side byte queue that sits directly upstream of `uart_tx`. It buffers host bytes in a 2^`depth_bits`-entry FIFO and launches them one at a time. For each byte it drives `DBUS`, pulses `txd_startH`, then waits for `txd_doneH` before launching the next. It decouples host write bursts from the serial bit rate.

## Interface
- `data_bits`, 8: width of one character; must match `uart_tx`.
- `depth_bits`, 4: log2 of FIFO depth (default 16 entries).
- `sysclk` in 1: system clock; all logic on rising edge.
- `rstH` in 1: one clock; reset is synchronous and active-high.
- `wr_data` in `data_bits`: byte from host.
- `wr_enH` in 1: write request, one byte per asserted cycle.
- `fullH` out 1: FIFO holds 2^`depth_bits` entries.
- `emptyH` out 1: FIFO holds 0 entries.
- `count` out `depth_bits`+1: current occupancy.
- `ovfH` out 1: write dropped (see Configuration).
- `DBUS` out `data_bits`: character to `uart_tx`.
- `txd_startH` out 1: start pulse to `uart_tx`.
- `txd_doneH` in 1: completion from `uart_tx`.
- `busyH` out 1: a character is launched and not yet done.

## Operation
- FIFO storage:
  - Storage is a register array with `rd_ptr` and `wr_ptr`, each `depth_bits` wide, wrapping modulo depth.
  - `count` is a separate `depth_bits`+1 counter.
- Write acceptance:
  - A write is accepted when `wr_enH` is high and either `count` < depth or a pop occurs on the same edge.
  - An accepted write stores `wr_data` at `wr_ptr` and increments `wr_ptr`.
  - A write while full with no same-edge pop is dropped: the FIFO is unchanged and `ovfH` is raised.
- Pop: occurs only on the IDLE→START transition. It loads `DBUS <= mem[rd_ptr]` and increments `rd_ptr`.
- Count update:
  - Push only: `count` increments.
  - Pop only: `count` decrements.
  - Push and pop on the same edge: `count` is unchanged.
- `fullH` and `emptyH` are decoded combinationally from `count`.
- `txd_doneH` edge detection:
  - `txd_doneH` is registered into `done_q`.
  - `done_rise = txd_doneH & ~done_q`.
  - This makes the queue correct whether `uart_tx` pulses or holds `txd_doneH`.
- FSM, 3 states:
  - IDLE: if `count` ≠ 0, pop, set `txd_startH` <= 1, and go to START.
  - START: set `txd_startH` <= 0 and go to WAIT.
  - WAIT: on `done_rise`, go to IDLE; otherwise stay.
- `busyH` = (state ≠ IDLE).
- `DBUS` holds its value from the pop until the next pop. It is never changed while in START or WAIT.
- `done_rise` is ignored in IDLE and START.

## Timing
- Reset values: `fullH`=0, `emptyH`=1, `count`=0, `ovfH`=0, `DBUS`=0, `txd_startH`=0, `busyH`=0, state IDLE.
  - Pointers reset to 0 and `done_q` resets to 0.
  - Memory contents are not reset.
- Write to start latency:
  - A write accepted at edge E0 into an empty queue while IDLE gives `count`=1 after E0.
  - At E1 the byte is popped; `DBUS` and `txd_startH`=1 are valid after E1.
  - `txd_startH` returns to 0 after E2.
- `txd_startH` is exactly one `sysclk` cycle wide.
- Back-to-back: after `done_rise` is seen in WAIT at edge Ek, IDLE pops the next byte at Ek+1. The minimum gap is therefore 1 idle cycle between characters.
- Reset mid-operation:
  - Asserting `rstH` in any state clears the FIFO, drops pending bytes, and forces IDLE with `txd_startH`=0.
  - `uart_tx` is reset independently.
- Pointer wrap: after 2^`depth_bits` writes, `wr_ptr` returns to 0. Ordering is preserved across the wrap.

## Configuration
- `UART_TXQ_OVF_STICKY_EN` defined: `ovfH` is sticky. It is set on the first dropped write and cleared only by `rstH`.
- Not defined: `ovfH` is a one-cycle pulse, registered, high for the cycle after each dropped write.
- FIFO and FSM behaviour are identical in both builds.

## Test plan
- Single byte:
  - Stimulus: write 8'hA5 while idle, then pulse `txd_doneH` 10 cycles after the start pulse.
  - Required: `txd_startH` is high exactly one cycle, 1 edge after the write, with `DBUS`=8'hA5; `busyH` is high from the start pulse until 1 cycle after `done_rise`; `emptyH` returns to 1.
- Burst ordering:
  - Stimulus: write 8'h01..8'h05 on consecutive cycles; emulate `uart_tx` by holding `txd_doneH` high for 3 cycles, 20 cycles after each start.
  - Required: 5 start pulses with `DBUS` = 01, 02, 03, 04, 05 in order; one start per done edge (a level done does not cause a double launch).
- Full/overflow:
  - Stimulus: with `txd_doneH` held 0, write 18 bytes.
  - Required: one pop, then 16 stored; `fullH`=1 and `count`=16; the 18th write is dropped.
  - `ovfH` is sticky with `UART_TXQ_OVF_STICKY_EN` and a 1-cycle pulse without it.
- Simultaneous push/pop when full:
  - Stimulus: with the FIFO full and IDLE entered via `done_rise`, write 8'h3C on the same cycle as the pop.
  - Required: the write is accepted, `count` stays 16, and no `ovfH`.
- Wrap-around:
  - Stimulus: stream 40 incrementing bytes, with done returned promptly.
  - Required: all 40 appear on `DBUS` in order across pointer wraps.
- Reset mid-WAIT:
  - Stimulus: assert `rstH` for 1 cycle while `busyH`=1 and 3 entries are queued.
  - Required: after the edge, `count`=0, `emptyH`=1, `busyH`=0, `txd_startH`=0, and no further start pulses.

Source files
------------

// File: rtl/uart_tx_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : uart_tx_queue                                                    |
// | Purpose  : Byte FIFO that launches characters one at a time into uart_tx.  |
// |            Build option UART_TXQ_OVF_STICKY_EN makes ovfH sticky.          |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module uart_tx_queue #(
   parameter int DATA_BITS  = 8,
   parameter int DEPTH_BITS = 4
) (
   input  logic                  sysclk,
   input  logic                  rstH,
   input  logic [DATA_BITS-1:0]  wr_data,
   input  logic                  wr_enH,
   output logic                  fullH,
   output logic                  emptyH,
   output logic [DEPTH_BITS:0]   count,
   output logic                  ovfH,
   output logic [DATA_BITS-1:0]  DBUS,
   output logic                  txd_startH,
   input  logic                  txd_doneH,
   output logic                  busyH
);

   localparam int                  c_DEPTH      = 1 << DEPTH_BITS;
   localparam logic [DEPTH_BITS:0] c_FULL_COUNT = (DEPTH_BITS+1)'(c_DEPTH);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_WAIT  = 2'd2
   } state_t;

   state_t                 state_q, state_d;
   logic [DATA_BITS-1:0]   mem_q [c_DEPTH];
   logic [DEPTH_BITS-1:0]  rd_ptr_q, wr_ptr_q;
   logic [DEPTH_BITS:0]    count_q, count_d;
   logic [DATA_BITS-1:0]   dbus_q;
   logic                   start_q, start_d;
   logic                   ovf_q, ovf_d;
   logic                   done_q;
   logic                   w_pop, w_push, w_drop, w_done_rise;

   // Edge detect so a level-held done from uart_tx launches only one character.
   assign w_done_rise = txd_doneH & ~done_q;

   always_comb begin
      state_d = state_q;
      start_d = 1'b0;
      w_pop   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (count_q != '0) begin
               w_pop   = 1'b1;
               start_d = 1'b1;
               state_d = S_START;
            end
         end
         S_START: state_d = S_WAIT;
         S_WAIT: begin
            if (w_done_rise) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // A full FIFO still accepts a write on the edge that frees a slot.
   assign w_push = wr_enH & ((count_q != c_FULL_COUNT) | w_pop);
   assign w_drop = wr_enH & ~w_push;

   always_comb begin
      count_d = count_q;
      case ({w_push, w_pop})
         2'b10:   count_d = count_q + (DEPTH_BITS+1)'(1);
         2'b01:   count_d = count_q - (DEPTH_BITS+1)'(1);
         default: count_d = count_q;
      endcase
   end

`ifdef UART_TXQ_OVF_STICKY_EN
   assign ovf_d = ovf_q | w_drop;
`else
   assign ovf_d = w_drop;
`endif

   always_ff @(posedge sysclk) begin
      if (rstH) begin
         state_q  <= S_IDLE;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         dbus_q   <= '0;
         start_q  <= 1'b0;
         ovf_q    <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         start_q <= start_d;
         ovf_q   <= ovf_d;
         done_q  <= txd_doneH;
         if (w_push) wr_ptr_q <= wr_ptr_q + DEPTH_BITS'(1);
         if (w_pop) begin
            dbus_q   <= mem_q[rd_ptr_q];
            rd_ptr_q <= rd_ptr_q + DEPTH_BITS'(1);
         end
      end
   end

   // Storage is deliberately left out of reset.
   always_ff @(posedge sysclk) begin
      if (w_push) mem_q[wr_ptr_q] <= wr_data;
   end

   assign fullH      = (count_q == c_FULL_COUNT);
   assign emptyH     = (count_q == '0);
   assign count      = count_q;
   assign ovfH       = ovf_q;
   assign DBUS       = dbus_q;
   assign txd_startH = start_q;
   assign busyH      = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_uart_tx_queue                                                 |
// | Purpose  : Scoreboard bench for uart_tx_queue with a uart_tx emulator.      |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_uart_tx_queue;

   localparam int c_DEPTH = 16;

   typedef struct {
      logic [4:0] cnt;
      logic       full;
      logic       empty;
      logic       busy;
      logic       start;
      logic       ovf;
      logic [7:0] dbus;
   } exp_t;

   logic       sysclk;
   logic       rstH;
   logic [7:0] wr_data;
   logic       wr_enH;
   logic       fullH, emptyH, ovfH, txd_startH, txd_doneH, busyH;
   logic [4:0] count;
   logic [7:0] DBUS;

   uart_tx_queue #(.DATA_BITS(8), .DEPTH_BITS(4)) dut (
      .sysclk     (sysclk),
      .rstH       (rstH),
      .wr_data    (wr_data),
      .wr_enH     (wr_enH),
      .fullH      (fullH),
      .emptyH     (emptyH),
      .count      (count),
      .ovfH       (ovfH),
      .DBUS       (DBUS),
      .txd_startH (txd_startH),
      .txd_doneH  (txd_doneH),
      .busyH      (busyH)
   );

   initial sysclk = 1'b0;
   always #5 sysclk = ~sysclk;

   exp_t       exp_q[$];
   logic [7:0] exp_dbus[$];
   int         n_vec = 0;
   int         n_mis = 0;

   // Reference model: queue of stored bytes plus the launch phase (0 idle, 1 start, 2 wait).
   logic [7:0] m_q[$];
   int         m_phase = 0;
   bit         m_doneq = 0;
   bit         m_ovf   = 0;
   logic [7:0] m_dbus  = 8'h00;

   // uart_tx emulator knobs.
   int g_dly = 5, g_hold = 1;
   bit g_noise = 0, g_manual = 0, g_done_val = 0;
   bit emu_active = 0;
   int emu_t = 0, hold_left = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_mis++;
         if (n_mis <= 40)
            $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, req);
      end
   endtask

   task automatic step(input bit wr, input logic [7:0] d, input bit rst);
      bit   done, rise, pop, push, drop;
      exp_t e;
      @(negedge sysclk);
      done = 1'b0;
      if (emu_active) begin
         emu_t++;
         if (emu_t > g_dly) begin
            emu_active = 0;
            hold_left  = g_hold;
         end
      end
      if (hold_left > 0) begin
         done = 1'b1;
         hold_left--;
      end else if (g_noise && !emu_active) begin
         done = ($urandom_range(0, 7) == 0);
      end
      if (g_manual) done = g_done_val;
      rstH = rst; wr_enH = wr; wr_data = d; txd_doneH = done;

      if (rst) begin
         m_q.delete();
         m_phase = 0; m_doneq = 0; m_ovf = 0; m_dbus = 8'h00;
         emu_active = 0; hold_left = 0;
      end else begin
         rise    = done && !m_doneq;
         m_doneq = done;
         pop  = (m_phase == 0) && (m_q.size() != 0);
         push = wr && ((m_q.size() < c_DEPTH) || pop);
         drop = wr && !push;
         if (pop) begin
            m_dbus = m_q.pop_front();
            exp_dbus.push_back(m_dbus);
         end
         if (push) m_q.push_back(d);
`ifdef UART_TXQ_OVF_STICKY_EN
         m_ovf = m_ovf || drop;
`else
         m_ovf = drop;
`endif
         if (m_phase == 0) begin
            if (pop) m_phase = 1;
         end else if (m_phase == 1) begin
            m_phase = 2;
         end else if (rise) begin
            m_phase = 0;
         end
         if (pop) begin
            emu_active = 1;
            emu_t      = 0;
         end
      end
      e.cnt   = 5'(m_q.size());
      e.full  = (m_q.size() == c_DEPTH);
      e.empty = (m_q.size() == 0);
      e.busy  = (m_phase != 0);
      e.start = (m_phase == 1);
      e.ovf   = m_ovf;
      e.dbus  = m_dbus;
      exp_q.push_back(e);
   endtask

   // Monitor: compares the post-edge state and matches each start pulse to a popped byte.
   always @(posedge sysclk) begin
      exp_t e;
      #1;
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         chk("count",      32'(count),      32'(e.cnt));
         chk("fullH",      32'(fullH),      32'(e.full));
         chk("emptyH",     32'(emptyH),     32'(e.empty));
         chk("busyH",      32'(busyH),      32'(e.busy));
         chk("txd_startH", 32'(txd_startH), 32'(e.start));
         chk("ovfH",       32'(ovfH),       32'(e.ovf));
         chk("DBUS",       32'(DBUS),       32'(e.dbus));
      end
      if (txd_startH === 1'b1) begin
         if (exp_dbus.size() == 0) begin
            n_vec++;
            n_mis++;
            $display("FAIL start_order at %0t: got start with DBUS=%0h, expected no start", $time, DBUS);
         end else begin
            chk("start_order", 32'(DBUS), 32'(exp_dbus.pop_front()));
         end
      end
   end

   initial begin
      int n;
      int guard;
      rstH = 1'b1; wr_enH = 1'b0; wr_data = 8'h00; txd_doneH = 1'b0;
      repeat (3) step(0, 8'h00, 1);

      // Single byte, done pulse 10 cycles after start.
      g_dly = 10; g_hold = 1;
      step(1, 8'hA5, 0);
      repeat (25) step(0, 8'h00, 0);

      // Burst with level-held done.
      g_dly = 20; g_hold = 3;
      for (int i = 1; i <= 5; i++) step(1, 8'(i), 0);
      repeat (140) step(0, 8'h00, 0);

      // Fill to full and overflow with done held low.
      g_manual = 1; g_done_val = 0;
      for (int i = 0; i < 18; i++) step(1, 8'($urandom), 0);
      repeat (3) step(0, 8'h00, 0);

      // Pop and push on the same edge while full.
      g_done_val = 1;
      step(0, 8'h00, 0);
      step(1, 8'h3C, 0);
      g_done_val = 0; g_manual = 0; g_dly = 2; g_hold = 1;
      repeat (150) step(0, 8'h00, 0);

      // Stream 40 incrementing bytes across pointer wraps.
      n = 0; guard = 0;
      while (n < 40 && guard < 2000) begin
         guard++;
         if (m_q.size() < c_DEPTH && $urandom_range(0, 1) == 1) begin
            step(1, 8'(8'h40 + n), 0);
            n++;
         end else begin
            step(0, 8'h00, 0);
         end
      end
      repeat (100) step(0, 8'h00, 0);

      // Random soak with done noise and occasional reset.
      g_noise = 1;
      for (int i = 0; i < 1500; i++) begin
         if (i % 200 == 0) begin
            g_hold = $urandom_range(1, 4);
            g_dly  = g_hold + 1 + $urandom_range(0, 10);
         end
         step($urandom_range(0, 2) == 0, 8'($urandom), $urandom_range(0, 299) == 0);
      end
      g_noise = 0;

      // Reset while waiting with entries queued.
      step(0, 8'h00, 1);
      g_manual = 1; g_done_val = 0;
      for (int i = 0; i < 4; i++) step(1, 8'($urandom), 0);
      repeat (3) step(0, 8'h00, 0);
      step(0, 8'h00, 1);
      g_manual = 0; g_dly = 2; g_hold = 1;
      repeat (20) step(0, 8'h00, 0);

      @(posedge sysclk);
      #3;
      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      chk("pending_starts",     32'(exp_dbus.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule
`default_nettype wire
